// File: rtl/id_rf_hilo_pkg.sv
// id_rf_hilo_pkg: shared widths, WB/EX/MEM bus layouts and the GPR read-mux helper
package id_rf_hilo_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 5;
    localparam int NREG        = 32;
    localparam int WB_TO_RF_WD = 1 + ADDR_W + DATA_W;
    localparam int HILO_BUS_WD = 2 + 2 * DATA_W;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } rf_wr_t;

    typedef struct packed {
        logic              hi_we;
        logic              lo_we;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_bus_t;

    // r0 always reads zero; otherwise a same-cycle write to the address wins over storage
    function automatic logic [DATA_W-1:0] rd_mux(
        input logic [ADDR_W-1:0] addr,
        input rf_wr_t            wr,
        input logic [DATA_W-1:0] stored
    );
        return (addr == '0) ? '0 : (wr.we && wr.waddr == addr) ? wr.wdata : stored;
    endfunction

endpackage

// File: rtl/id_rf_hilo_hilo_reg.sv
// id_rf_hilo_hilo_reg: HI/LO storage written by WB, read through EX > MEM > WB > stored forwarding
module id_rf_hilo_hilo_reg
    import id_rf_hilo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  hilo_bus_t         wb,
    input  hilo_bus_t         mem,
    input  hilo_bus_t         ex,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata
);

    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

    // only WB commits; each half has its own enable
    always_comb begin
        hi_d = wb.hi_we ? wb.hi : hi_q;
        lo_d = wb.lo_we ? wb.lo : lo_q;
    end

    // state register; reset overrides a concurrent WB write
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // youngest in-flight producer wins, per half
    always_comb begin
        hi_rdata = ex.hi_we ? ex.hi : mem.hi_we ? mem.hi : wb.hi_we ? wb.hi : hi_q;
        lo_rdata = ex.lo_we ? ex.lo : mem.lo_we ? mem.lo : wb.lo_we ? wb.lo : lo_q;
    end

endmodule

// File: rtl/id_rf_hilo.sv
// id_rf_hilo: 32x32 GPR file with WB write-through bypass plus forwarded HI/LO pair
module id_rf_hilo
    import id_rf_hilo_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [HILO_BUS_WD-1:0] wb_hilo_bus,
    input  logic [HILO_BUS_WD-1:0] mem_hilo_bus,
    input  logic [HILO_BUS_WD-1:0] ex_hilo_bus,
    input  logic [ADDR_W-1:0]      raddr1,
    input  logic [ADDR_W-1:0]      raddr2,
    output logic [DATA_W-1:0]      rdata1,
    output logic [DATA_W-1:0]      rdata2,
    output logic [DATA_W-1:0]      hi_rdata,
    output logic [DATA_W-1:0]      lo_rdata
);

    rf_wr_t            wr;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    assign wr = rf_wr_t'(wb_to_rf_bus);

    // next array state; writes to r0 are dropped so it keeps its reset zero
    always_comb begin
        regs_d = regs_q;
        if (wr.we && wr.waddr != '0) regs_d[wr.waddr] = wr.wdata;
    end

    // commit on posedge; reset clears everything and beats any write
    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    // two independent zero-latency read ports with write-through
    always_comb begin
        rdata1 = rd_mux(raddr1, wr, regs_q[raddr1]);
        rdata2 = rd_mux(raddr2, wr, regs_q[raddr2]);
    end

    id_rf_hilo_hilo_reg u_hilo (
        .clk      (clk),
        .rst      (rst),
        .wb       (hilo_bus_t'(wb_hilo_bus)),
        .mem      (hilo_bus_t'(mem_hilo_bus)),
        .ex       (hilo_bus_t'(ex_hilo_bus)),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata)
    );

endmodule

// File: tb/tb_id_rf_hilo.sv
// tb_id_rf_hilo: directed spec scenarios plus randomized traffic against a behavioural model
module tb_id_rf_hilo;
    import id_rf_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    rf_wr_t      wr;
    hilo_bus_t   wb, mem, ex;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2, hi_rdata, lo_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_hi, m_lo;

    id_rf_hilo dut (
        .clk          (clk),
        .rst          (rst),
        .wb_to_rf_bus (wr),
        .wb_hilo_bus  (wb),
        .mem_hilo_bus (mem),
        .ex_hilo_bus  (ex),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .hi_rdata     (hi_rdata),
        .lo_rdata     (lo_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr.we && wr.waddr == a) return wr.wdata;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_hi();
        if (ex.hi_we) return ex.hi;
        if (mem.hi_we) return mem.hi;
        if (wb.hi_we) return wb.hi;
        return m_hi;
    endfunction

    function automatic logic [31:0] exp_lo();
        if (ex.lo_we) return ex.lo;
        if (mem.lo_we) return mem.lo;
        if (wb.lo_we) return wb.lo;
        return m_lo;
    endfunction

    task automatic idle();
        wr = '0; wb = '0; mem = '0; ex = '0; rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else begin
            if (wr.we && wr.waddr != 0) m_regs[wr.waddr] = wr.wdata;
            if (wb.hi_we) m_hi = wb.hi;
            if (wb.lo_we) m_lo = wb.lo;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        raddr1 = 5'd5; raddr2 = 5'd31;
        #1;
        n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL reset_rd1 got %h exp %h", rdata1, 32'h0); end
        n_cmp++; if (rdata2 !== 32'h0) begin n_err++; $display("FAIL reset_rd2 got %h exp %h", rdata2, 32'h0); end
        n_cmp++; if (hi_rdata !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h exp %h", hi_rdata, 32'h0); end
        n_cmp++; if (lo_rdata !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h exp %h", lo_rdata, 32'h0); end
        wr = '{1'b1, 5'd5, 32'h1234};
        wb = '{1'b1, 1'b1, 32'h77, 32'h88};
        tick();
        idle();
        #1;
        n_cmp++; if (rdata1 !== 32'h1234) begin n_err++; $display("FAIL reset_x5_written got %h exp %h", rdata1, 32'h1234); end
        rst = 1'b1;
        tick();
        idle();
        #1;
        n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL reset_x5_cleared got %h exp %h", rdata1, 32'h0); end
        n_cmp++; if (hi_rdata !== 32'h0) begin n_err++; $display("FAIL reset_hi_cleared got %h exp %h", hi_rdata, 32'h0); end
        n_cmp++; if (lo_rdata !== 32'h0) begin n_err++; $display("FAIL reset_lo_cleared got %h exp %h", lo_rdata, 32'h0); end
    endtask

    task automatic test_bypass();
        idle();
        wr = '{1'b1, 5'd7, 32'hDEADBEEF};
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        n_cmp++; if (rdata1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_rd1 got %h exp %h", rdata1, 32'hDEADBEEF); end
        n_cmp++; if (rdata2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_rd2 got %h exp %h", rdata2, 32'hDEADBEEF); end
        tick();
        idle();
        #1;
        n_cmp++; if (rdata1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_rd1 got %h exp %h", rdata1, 32'hDEADBEEF); end
        n_cmp++; if (rdata2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_rd2 got %h exp %h", rdata2, 32'hDEADBEEF); end
    endtask

    task automatic test_r0();
        idle();
        wr = '{1'b1, 5'd0, 32'hFFFFFFFF};
        raddr1 = 5'd0; raddr2 = 5'd7;
        #1;
        n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL r0_same got %h exp %h", rdata1, 32'h0); end
        n_cmp++; if (rdata2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL r0_other got %h exp %h", rdata2, 32'hDEADBEEF); end
        tick();
        idle();
        #1;
        n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL r0_next got %h exp %h", rdata1, 32'h0); end
    endtask

    task automatic test_hilo_split();
        idle();
        wb = '{1'b1, 1'b0, 32'hAAAA0000, 32'h5555};
        tick();
        idle();
        #1;
        n_cmp++; if (hi_rdata !== 32'hAAAA0000) begin n_err++; $display("FAIL split_hi got %h exp %h", hi_rdata, 32'hAAAA0000); end
        n_cmp++; if (lo_rdata !== 32'h0) begin n_err++; $display("FAIL split_lo got %h exp %h", lo_rdata, 32'h0); end
    endtask

    task automatic test_forward();
        idle();
        ex  = '{1'b1, 1'b0, 32'h1, 32'hE0};
        mem = '{1'b1, 1'b1, 32'h2, 32'hF0};
        wb  = '{1'b1, 1'b0, 32'h3, 32'hD0};
        #1;
        n_cmp++; if (hi_rdata !== 32'h1) begin n_err++; $display("FAIL fwd_ex got %h exp %h", hi_rdata, 32'h1); end
        n_cmp++; if (lo_rdata !== 32'hF0) begin n_err++; $display("FAIL fwd_lo_mem got %h exp %h", lo_rdata, 32'hF0); end
        ex = '0;
        #1;
        n_cmp++; if (hi_rdata !== 32'h2) begin n_err++; $display("FAIL fwd_mem got %h exp %h", hi_rdata, 32'h2); end
        mem = '0;
        #1;
        n_cmp++; if (hi_rdata !== 32'h3) begin n_err++; $display("FAIL fwd_wb got %h exp %h", hi_rdata, 32'h3); end
        n_cmp++; if (lo_rdata !== 32'h0) begin n_err++; $display("FAIL fwd_lo_stored got %h exp %h", lo_rdata, 32'h0); end
        tick();
        idle();
        #1;
        n_cmp++; if (hi_rdata !== 32'h3) begin n_err++; $display("FAIL fwd_stored got %h exp %h", hi_rdata, 32'h3); end
    endtask

    task automatic test_reset_concurrent();
        idle();
        wr = '{1'b1, 5'd9, 32'h99};
        tick();
        wr = '{1'b1, 5'd9, 32'h1111};
        wb = '{1'b1, 1'b1, 32'h2222, 32'h3333};
        rst = 1'b1;
        tick();
        idle();
        raddr1 = 5'd9;
        #1;
        n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL rstwin_x9 got %h exp %h", rdata1, 32'h0); end
        n_cmp++; if (hi_rdata !== 32'h0) begin n_err++; $display("FAIL rstwin_hi got %h exp %h", hi_rdata, 32'h0); end
        n_cmp++; if (lo_rdata !== 32'h0) begin n_err++; $display("FAIL rstwin_lo got %h exp %h", lo_rdata, 32'h0); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle();
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 2) != 0) wr = '{1'b1, 5'($urandom_range(0, 31)), $urandom};
            if ($urandom_range(0, 1) != 0) wb = '{1'($urandom), 1'($urandom), $urandom, $urandom};
            if ($urandom_range(0, 2) == 0) mem = '{1'($urandom), 1'($urandom), $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ex = '{1'($urandom), 1'($urandom), $urandom, $urandom};
            raddr1 = ($urandom_range(0, 3) == 0) ? wr.waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            #1;
            n_cmp++; if (rdata1 !== exp_rd(raddr1)) begin n_err++; $display("FAIL rnd_rd1 cyc %0d a %0d got %h exp %h", c, raddr1, rdata1, exp_rd(raddr1)); end
            n_cmp++; if (rdata2 !== exp_rd(raddr2)) begin n_err++; $display("FAIL rnd_rd2 cyc %0d a %0d got %h exp %h", c, raddr2, rdata2, exp_rd(raddr2)); end
            n_cmp++; if (hi_rdata !== exp_hi()) begin n_err++; $display("FAIL rnd_hi cyc %0d got %h exp %h", c, hi_rdata, exp_hi()); end
            n_cmp++; if (lo_rdata !== exp_lo()) begin n_err++; $display("FAIL rnd_lo cyc %0d got %h exp %h", c, lo_rdata, exp_lo()); end
            tick();
        end
    endtask

    initial begin
        idle();
        raddr1 = '0; raddr2 = '0;
        rst = 1'b1;
        @(negedge clk);
        tick();
        test_reset();
        test_bypass();
        test_r0();
        test_hilo_split();
        test_forward();
        test_reset_concurrent();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
